// File: rtl/ls1u_bus_pkg.sv
// Shared encodings for the shrunk 8-bit AHB bus and the SPI master register map.
package ls1u_bus_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_DIV  = 2'd3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_RXV     = 1;
  localparam int CTRL_CS      = 0;
  localparam int CTRL_DEV_LSB = 1;
  localparam int CTRL_DEV_MSB = 4;
  localparam int CTRL_IE      = 7;

  typedef enum logic [1:0] {
    ENG_IDLE  = 2'd0,
    ENG_SHIFT = 2'd1,
    ENG_DONE  = 2'd2
  } eng_state_e;

endpackage

// File: rtl/ahb8_spi_master_if.sv
// Shrunk AHB responder bundle: 24-bit address, 8-bit data, single hready.
interface ahb8_spi_master_if;
  logic        hsel;
  logic [23:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [7:0]  hwdata;
  logic [7:0]  hrdata;
  logic        hready;
  logic        hresp;

  modport master (
    output hsel, haddr, hwrite, htrans, hburst, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, haddr, hwrite, htrans, hburst, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI mode-0 byte engine: MSB first, SCK half-period of (div+1) clk cycles.
module spi_shift_engine
  import ls1u_bus_pkg::*;
(
  input  logic       clk,
  input  logic       hreset_n,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic [7:0] div,
  input  logic       miso,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx,
  output logic       mclk,
  output logic       mosi
);

  eng_state_e state_reg, state_next;
  logic [7:0] cnt_reg;
  logic [3:0] half_reg;
  logic [7:0] tx_sh_reg;
  logic [7:0] rx_sh_reg;
  logic [7:0] rx_reg;
  logic       mclk_reg;
  logic       tick;

  assign tick = (state_reg == ENG_SHIFT) && (cnt_reg == div);

  always_ff @(posedge clk or negedge hreset_n) begin
    if (!hreset_n) state_reg <= ENG_IDLE;
    else           state_reg <= state_next;
  end

  // DONE may restart directly so a stalled DATA write costs no extra cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ENG_IDLE:  if (start) state_next = ENG_SHIFT;
      ENG_SHIFT: if (tick && (half_reg == 4'd15)) state_next = ENG_DONE;
      ENG_DONE:  state_next = start ? ENG_SHIFT : ENG_IDLE;
      default:   state_next = ENG_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == ENG_SHIFT);
    done = (state_reg == ENG_DONE);
  end

  always_ff @(posedge clk or negedge hreset_n) begin
    if (!hreset_n) begin
      cnt_reg   <= 8'd0;
      half_reg  <= 4'd0;
      tx_sh_reg <= 8'd0;
      rx_sh_reg <= 8'd0;
      rx_reg    <= 8'd0;
      mclk_reg  <= 1'b0;
    end else begin
      if (state_reg == ENG_DONE) rx_reg <= rx_sh_reg;
      if (start && (state_reg != ENG_SHIFT)) begin
        cnt_reg   <= 8'd0;
        half_reg  <= 4'd0;
        mclk_reg  <= 1'b0;
        tx_sh_reg <= tx;
      end else if (state_reg == ENG_SHIFT) begin
        if (tick) begin
          cnt_reg  <= 8'd0;
          half_reg <= half_reg + 4'd1;
          mclk_reg <= ~mclk_reg;
          // rising edge samples miso, falling edge advances mosi
          if (!mclk_reg) rx_sh_reg <= {rx_sh_reg[6:0], miso};
          else           tx_sh_reg <= {tx_sh_reg[6:0], 1'b0};
        end else begin
          cnt_reg <= cnt_reg + 8'd1;
        end
      end
    end
  end

  assign rx   = rx_reg;
  assign mclk = mclk_reg;
  assign mosi = tx_sh_reg[7];

endmodule

// File: rtl/ahb8_spi_master.sv
// AHB-attached SPI master: four byte registers, DATA writes stall while a byte is shifting.
module ahb8_spi_master
  import ls1u_bus_pkg::*;
#(
  parameter logic [7:0] DIV_RST = 8'd3
) (
  input  logic                     clk,
  input  logic                     hreset_n,
  ahb8_spi_master_if.slave         bus,
  output logic                     irq,
  output logic                     spi_cs,
  output logic [3:0]               spi_devsel,
  output logic                     mosi,
  output logic                     mclk,
  input  logic                     miso
);

  logic       dp_valid_reg;
  logic       dp_write_reg;
  logic [1:0] dp_addr_reg;
  logic       cs_reg;
  logic [3:0] dev_reg;
  logic       ie_reg;
  logic [7:0] div_reg;
  logic       rxv_reg;

  logic       eng_busy;
  logic       eng_done;
  logic [7:0] eng_rx;
  logic       addr_accept;
  logic       stall;
  logic       wr_en;
  logic       rd_en;
  logic       start;
  logic [7:0] rdata;
  logic       unused_bits;

  assign stall       = dp_valid_reg && dp_write_reg && (dp_addr_reg == REG_DATA) && eng_busy;
  assign addr_accept = bus.hsel && !stall &&
                       ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));
  assign wr_en       = dp_valid_reg && dp_write_reg && !stall;
  assign rd_en       = dp_valid_reg && !dp_write_reg;
  assign start       = wr_en && (dp_addr_reg == REG_DATA);

  // a stalled data phase keeps its registered address until it completes
  always_ff @(posedge clk or negedge hreset_n) begin
    if (!hreset_n) begin
      dp_valid_reg <= 1'b0;
      dp_write_reg <= 1'b0;
      dp_addr_reg  <= 2'd0;
    end else if (!stall) begin
      dp_valid_reg <= addr_accept;
      dp_write_reg <= bus.hwrite;
      dp_addr_reg  <= bus.haddr[1:0];
    end
  end

  always_ff @(posedge clk or negedge hreset_n) begin
    if (!hreset_n) begin
      cs_reg  <= 1'b1;
      dev_reg <= 4'd0;
      ie_reg  <= 1'b0;
      div_reg <= DIV_RST;
      rxv_reg <= 1'b0;
    end else begin
      if (wr_en && (dp_addr_reg == REG_CTRL)) begin
        cs_reg  <= bus.hwdata[CTRL_CS];
        dev_reg <= bus.hwdata[CTRL_DEV_MSB:CTRL_DEV_LSB];
        ie_reg  <= bus.hwdata[CTRL_IE];
      end
      if (wr_en && (dp_addr_reg == REG_DIV)) div_reg <= bus.hwdata;
      // completion beats a coincident DATA read
      if (eng_done)                                rxv_reg <= 1'b1;
      else if (rd_en && (dp_addr_reg == REG_DATA)) rxv_reg <= 1'b0;
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (rd_en) begin
      case (dp_addr_reg)
        REG_DATA: rdata = eng_rx;
        REG_STAT: begin
          rdata[STAT_BUSY] = eng_busy;
          rdata[STAT_RXV]  = rxv_reg;
        end
        REG_CTRL: begin
          rdata[CTRL_CS]                   = cs_reg;
          rdata[CTRL_DEV_MSB:CTRL_DEV_LSB] = dev_reg;
          rdata[CTRL_IE]                   = ie_reg;
        end
        default:  rdata = div_reg;
      endcase
    end
  end

  spi_shift_engine u_engine (
    .clk      (clk),
    .hreset_n (hreset_n),
    .start    (start),
    .tx       (bus.hwdata),
    .div      (div_reg),
    .miso     (miso),
    .busy     (eng_busy),
    .done     (eng_done),
    .rx       (eng_rx),
    .mclk     (mclk),
    .mosi     (mosi)
  );

  assign bus.hrdata = rdata;
  assign bus.hready = !stall;
  assign bus.hresp  = 1'b0;
  assign irq        = rxv_reg && ie_reg;
  assign spi_cs     = cs_reg;
  assign spi_devsel = dev_reg;

  assign unused_bits = ^{bus.haddr[23:2], bus.hburst};

endmodule

// File: tb/tb_ahb8_spi_master.sv
// Directed bench for ahb8_spi_master: register access, SPI timing, stall, DONE race, reset abort.
module tb_ahb8_spi_master;
  import ls1u_bus_pkg::*;

  logic       clk = 1'b0;
  logic       hreset_n;
  logic       irq;
  logic       spi_cs;
  logic [3:0] spi_devsel;
  logic       mosi;
  logic       mclk;
  logic       miso;
  logic       loop_en;
  logic [7:0] miso_pat = 8'hC3;
  logic [2:0] fall_cnt = 3'd0;
  int         n_cmp = 0;
  int         n_err = 0;

  ahb8_spi_master_if bus ();

  ahb8_spi_master #(.DIV_RST(8'd3)) dut (
    .clk        (clk),
    .hreset_n   (hreset_n),
    .bus        (bus),
    .irq        (irq),
    .spi_cs     (spi_cs),
    .spi_devsel (spi_devsel),
    .mosi       (mosi),
    .mclk       (mclk),
    .miso       (miso)
  );

  always #5 clk = ~clk;

  // external slave model: shifts the next pattern bit out on each falling SCK
  always @(negedge mclk) if (hreset_n) fall_cnt <= fall_cnt + 3'd1;
  assign miso = loop_en ? mosi : miso_pat[3'd7 - fall_cnt];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ahb_write(input logic [1:0] addr, input logic [7:0] data, output int waits);
    waits = 0;
    bus.hsel = 1'b1; bus.haddr = {22'h0, addr}; bus.hwrite = 1'b1; bus.htrans = HTRANS_NONSEQ;
    @(posedge clk); #1;
    bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE; bus.hwrite = 1'b0; bus.hwdata = data;
    @(negedge clk);
    while ((bus.hready !== 1'b1) && (waits < 200)) begin
      waits++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    $display("write a=%0d d=0x%02h waits=%0d", addr, data, waits);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [7:0] data);
    int w;
    ahb_write(addr, data, w);
    chk("write_no_wait", w, 0);
  endtask

  task automatic ahb_read(input logic [1:0] addr, output logic [7:0] data);
    bus.hsel = 1'b1; bus.haddr = {22'h0, addr}; bus.hwrite = 1'b0; bus.htrans = HTRANS_NONSEQ;
    @(posedge clk); #1;
    bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE;
    @(negedge clk);
    data = bus.hrdata;
    @(posedge clk); #1;
    $display("read  a=%0d d=0x%02h", addr, data);
  endtask

  task automatic ignored_beat(input logic sel, input logic [1:0] trans, output logic rdy);
    bus.hsel = sel; bus.haddr = {22'h0, REG_CTRL}; bus.hwrite = 1'b1; bus.htrans = trans;
    @(posedge clk); #1;
    bus.hsel = 1'b0; bus.htrans = HTRANS_IDLE; bus.hwrite = 1'b0; bus.hwdata = 8'h7A;
    @(negedge clk);
    rdy = bus.hready;
    @(posedge clk); #1;
    $display("ignored beat sel=%0d htrans=%0d hready=%0d", sel, trans, rdy);
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] mosi_bits;
    logic       prev;
    logic       mclk_before;
    logic       rdy;
    int         waits;
    int         togg;
    int         first_t;
    int         last_t;
    int         rises;
    int         tries;
    logic       found;

    hreset_n = 1'b1; loop_en = 1'b1;
    bus.hsel = 1'b0; bus.haddr = 24'h0; bus.hwrite = 1'b0; bus.htrans = HTRANS_IDLE;
    bus.hburst = 3'd0; bus.hwdata = 8'h00;
    #2 hreset_n = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_hrdata", bus.hrdata, 8'h00);
    chk("rst_hready", bus.hready, 1'b1);
    chk("rst_hresp", bus.hresp, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_cs", spi_cs, 1'b1);
    chk("rst_devsel", spi_devsel, 4'd0);
    chk("rst_mclk", mclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    @(posedge clk); #1 hreset_n = 1'b1;
    ahb_read(REG_STAT, rd); chk("rst_stat", rd, 8'h00);
    ahb_read(REG_CTRL, rd); chk("rst_ctrl", rd, 8'h01);
    ahb_read(REG_DIV, rd);  chk("rst_div", rd, 8'h03);

    // DIV=0 loopback transfer of 0xA5
    wr(REG_CTRL, 8'h84);
    wr(REG_DIV, 8'h00);
    chk("ctrl_cs", spi_cs, 1'b0);
    chk("ctrl_dev", spi_devsel, 4'd2);
    wr(REG_DATA, 8'hA5);
    prev = mclk; togg = 0; first_t = -1; last_t = -1; mosi_bits = 8'h00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mclk !== prev) begin
        togg++;
        if (first_t < 0) first_t = c;
        last_t = c;
        if (mclk) mosi_bits = {mosi_bits[6:0], mosi};
      end
      prev = mclk;
    end
    @(posedge clk); #1;
    chk("a5_toggles", togg, 16);
    chk("a5_first_toggle", first_t, 1);
    chk("a5_last_toggle", last_t, 16);
    chk("a5_mosi_bits", mosi_bits, 8'hA5);
    ahb_read(REG_STAT, rd); chk("a5_stat", rd, 8'h02);
    chk("a5_irq", irq, 1'b1);
    ahb_read(REG_DATA, rd); chk("a5_data", rd, 8'hA5);
    ahb_read(REG_STAT, rd); chk("a5_stat_clr", rd, 8'h00);
    chk("a5_irq_clr", irq, 1'b0);

    // DIV=3, back-to-back DATA writes, second one stalls
    wr(REG_DIV, 8'h03);
    loop_en = 1'b0;
    ahb_write(REG_DATA, 8'h3C, waits); chk("b2b_first_waits", waits, 0);
    ahb_write(REG_DATA, 8'hFF, waits); chk("b2b_stall_waits", waits, 63);
    ahb_read(REG_STAT, rd); chk("b2b_stat_busy_rxv", rd, 8'h03);
    ahb_read(REG_DATA, rd); chk("b2b_rx1", rd, 8'hC3);
    ahb_read(REG_STAT, rd); chk("b2b_stat_busy", rd, 8'h01);
    tries = 0;
    do begin
      ahb_read(REG_STAT, rd);
      tries++;
    end while (rd[0] && (tries < 100));
    chk("b2b_stat_done", rd, 8'h02);
    ahb_read(REG_DATA, rd); chk("b2b_rx2", rd, 8'hC3);

    // ignored beats and read-only STAT
    ignored_beat(1'b1, HTRANS_IDLE, rdy);   chk("idle_hready", rdy, 1'b1);
    ahb_read(REG_CTRL, rd);                 chk("idle_ctrl", rd, 8'h84);
    ignored_beat(1'b1, HTRANS_BUSY, rdy);   chk("busy_hready", rdy, 1'b1);
    ahb_read(REG_CTRL, rd);                 chk("busy_ctrl", rd, 8'h84);
    ignored_beat(1'b0, HTRANS_NONSEQ, rdy); chk("nosel_hready", rdy, 1'b1);
    ahb_read(REG_CTRL, rd);                 chk("nosel_ctrl", rd, 8'h84);
    wr(REG_STAT, 8'hFF);
    ahb_read(REG_STAT, rd);                 chk("stat_ro", rd, 8'h00);

    // DATA read landing on the DONE cycle
    wr(REG_DIV, 8'h00);
    loop_en = 1'b1;
    wr(REG_DATA, 8'h96);
    repeat (15) begin @(posedge clk); #1; end
    ahb_read(REG_DATA, rd); chk("race_old_rx", rd, 8'hC3);
    ahb_read(REG_STAT, rd); chk("race_rxv_set", rd, 8'h02);
    chk("race_irq", irq, 1'b1);
    ahb_read(REG_DATA, rd); chk("race_new_rx", rd, 8'h96);

    // reset at bit 4 of a transfer
    wr(REG_DIV, 8'h01);
    wr(REG_DATA, 8'hFF);
    prev = mclk; rises = 0; found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (mclk && !prev) rises++;
      prev = mclk;
      if (rises == 4) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_bit4_reached", found, 1'b1);
    mclk_before = mclk;
    chk("abort_mclk_before", mclk_before, 1'b1);
    hreset_n = 1'b0;
    #1;
    chk("abort_mclk", mclk, 1'b0);
    chk("abort_mosi", mosi, 1'b0);
    chk("abort_cs", spi_cs, 1'b1);
    chk("abort_devsel", spi_devsel, 4'd0);
    chk("abort_hready", bus.hready, 1'b1);
    chk("abort_hrdata", bus.hrdata, 8'h00);
    chk("abort_irq", irq, 1'b0);
    @(posedge clk); #1 hreset_n = 1'b1;
    ahb_read(REG_DIV, rd);  chk("abort_div", rd, 8'h03);
    ahb_read(REG_STAT, rd); chk("abort_stat", rd, 8'h00);
    wr(REG_DIV, 8'h00);
    wr(REG_DATA, 8'h5A);
    repeat (20) begin @(posedge clk); #1; end
    ahb_read(REG_STAT, rd); chk("post_stat", rd, 8'h02);
    chk("post_irq_ie0", irq, 1'b0);
    ahb_read(REG_DATA, rd); chk("post_data", rd, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
